// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the system ID / build timestamp checker.
package sysid_check_pkg;

   localparam int unsigned SYSID_DATA_W = 32;

   localparam logic SYSID_ADDR_ID = 1'b0;
   localparam logic SYSID_ADDR_TS = 1'b1;

   typedef enum logic [2:0] {
      StIdle,
      StReqId,
      StWaitId,
      StReqTs,
      StWaitTs,
      StDone
   } sysid_state_t;

endpackage

// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only link between the checker (master) and the sysid slave.
interface sysid_checker_if;
   import sysid_check_pkg::*;

   logic                    avm_address;
   logic                    avm_read;
   logic                    avm_waitrequest;
   logic [SYSID_DATA_W-1:0] avm_readdata;
   logic                    avm_readdatavalid;

   modport master (
      output avm_address,
      output avm_read,
      input  avm_waitrequest,
      input  avm_readdata,
      input  avm_readdatavalid
   );

   modport slave (
      input  avm_address,
      input  avm_read,
      output avm_waitrequest,
      output avm_readdata,
      output avm_readdatavalid
   );

endinterface

// File: rtl/sysid_checker.sv
// Reads sysid word 0 (ID) and word 1 (timestamp), compares them against build-time
// values and reports pass / fail / timeout.
module sysid_checker
   import sysid_check_pkg::*;
#(
   parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID        = 32'd0,
   parameter logic [SYSID_DATA_W-1:0] EXPECTED_TIMESTAMP = 32'd1434373291,
   parameter int unsigned             TIMEOUT_CYCLES     = 1024,
   parameter bit                      AUTO_START         = 1'b1
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    start,
   sysid_checker_if.master         avm,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic                    id_ok,
   output logic                    ts_ok,
   output logic                    timeout,
   output logic [SYSID_DATA_W-1:0] id_value,
   output logic [SYSID_DATA_W-1:0] ts_value
);

   localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   sysid_state_t     state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             auto_q;
   logic             read_q;
   logic             addr_q;

   logic accept;
   logic capture;
   logic expire;
   logic in_read;
   logic is_id;
   logic match_id;
   logic match_ts;

   assign avm.avm_read    = read_q;
   assign avm.avm_address = addr_q;

   always_comb begin
      accept   = read_q & ~avm.avm_waitrequest;
      capture  = 1'b0;
      in_read  = 1'b0;
      is_id    = 1'b0;
      case (state_q)
         StReqId: begin
            in_read = 1'b1;
            is_id   = 1'b1;
            capture = accept & avm.avm_readdatavalid;
         end
         StWaitId: begin
            in_read = 1'b1;
            is_id   = 1'b1;
            capture = avm.avm_readdatavalid;
         end
         StReqTs: begin
            in_read = 1'b1;
            capture = accept & avm.avm_readdatavalid;
         end
         StWaitTs: begin
            in_read = 1'b1;
            capture = avm.avm_readdatavalid;
         end
         default: begin
            in_read = 1'b0;
         end
      endcase
      // A capture landing on the last allowed cycle still counts as a good read.
      expire   = (cnt_q == CNT_LAST) & ~capture;
      match_id = (avm.avm_readdata == EXPECTED_ID);
      match_ts = (avm.avm_readdata == EXPECTED_TIMESTAMP);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         auto_q   <= AUTO_START;
         read_q   <= 1'b0;
         addr_q   <= SYSID_ADDR_ID;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         id_ok    <= 1'b0;
         ts_ok    <= 1'b0;
         timeout  <= 1'b0;
         id_value <= '0;
         ts_value <= '0;
      end else begin
         auto_q <= 1'b0;
         if (state_q == StIdle) begin
            if (start || auto_q) begin
               state_q <= StReqId;
               read_q  <= 1'b1;
               addr_q  <= SYSID_ADDR_ID;
               cnt_q   <= '0;
               busy    <= 1'b1;
               done    <= 1'b0;
               pass    <= 1'b0;
               id_ok   <= 1'b0;
               ts_ok   <= 1'b0;
               timeout <= 1'b0;
            end
         end else if (state_q == StDone) begin
            state_q <= StIdle;
         end else if (in_read) begin
            cnt_q <= cnt_q + 1'b1;
            if (accept) begin
               read_q <= 1'b0;
            end
            if (capture && is_id) begin
               id_value <= avm.avm_readdata;
               id_ok    <= match_id;
               state_q  <= StReqTs;
               read_q   <= 1'b1;
               addr_q   <= SYSID_ADDR_TS;
               cnt_q    <= '0;
            end else if (capture) begin
               ts_value <= avm.avm_readdata;
               ts_ok    <= match_ts;
               pass     <= id_ok & match_ts;
               state_q  <= StDone;
               done     <= 1'b1;
               busy     <= 1'b0;
            end else if (expire) begin
               state_q <= StDone;
               read_q  <= 1'b0;
               timeout <= 1'b1;
               pass    <= 1'b0;
               done    <= 1'b1;
               busy    <= 1'b0;
            end else if (accept) begin
               state_q <= is_id ? StWaitId : StWaitTs;
            end
         end
      end
   end

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench: two checker instances (auto-start with short timeout, manual start)
// sharing one behavioural sysid slave selected by sel.
module tb_sysid_checker;
   import sysid_check_pkg::*;

   localparam logic [31:0] EXP_TS = 32'd1434373291;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic rst_a_n, rst_b_n, start_cmd, sel;
   logic start_a, start_b;
   assign start_a = start_cmd & ~sel;
   assign start_b = start_cmd & sel;

   sysid_checker_if bus_a ();
   sysid_checker_if bus_b ();

   logic        busy_a, done_a, pass_a, id_ok_a, ts_ok_a, timeout_a;
   logic        busy_b, done_b, pass_b, id_ok_b, ts_ok_b, timeout_b;
   logic [31:0] id_value_a, ts_value_a, id_value_b, ts_value_b;

   sysid_checker #(.TIMEOUT_CYCLES(16), .AUTO_START(1'b1)) dut_a (
      .clock    (clock),
      .reset_n  (rst_a_n),
      .start    (start_a),
      .avm      (bus_a),
      .busy     (busy_a),
      .done     (done_a),
      .pass     (pass_a),
      .id_ok    (id_ok_a),
      .ts_ok    (ts_ok_a),
      .timeout  (timeout_a),
      .id_value (id_value_a),
      .ts_value (ts_value_a)
   );

   sysid_checker #(.AUTO_START(1'b0)) dut_b (
      .clock    (clock),
      .reset_n  (rst_b_n),
      .start    (start_b),
      .avm      (bus_b),
      .busy     (busy_b),
      .done     (done_b),
      .pass     (pass_b),
      .id_ok    (id_ok_b),
      .ts_ok    (ts_ok_b),
      .timeout  (timeout_b),
      .id_value (id_value_b),
      .ts_value (ts_value_b)
   );

   // View of the selected instance
   logic        m_read, m_addr, m_busy, m_done, m_pass, m_id_ok, m_ts_ok, m_timeout;
   logic [31:0] m_id_value, m_ts_value;
   assign m_read     = sel ? bus_b.avm_read    : bus_a.avm_read;
   assign m_addr     = sel ? bus_b.avm_address : bus_a.avm_address;
   assign m_busy     = sel ? busy_b     : busy_a;
   assign m_done     = sel ? done_b     : done_a;
   assign m_pass     = sel ? pass_b     : pass_a;
   assign m_id_ok    = sel ? id_ok_b    : id_ok_a;
   assign m_ts_ok    = sel ? ts_ok_b    : ts_ok_a;
   assign m_timeout  = sel ? timeout_b  : timeout_a;
   assign m_id_value = sel ? id_value_b : id_value_a;
   assign m_ts_value = sel ? ts_value_b : ts_value_a;

   // Slave model, driven on the falling edge
   logic        s_wait = 1'b0, s_rdv = 1'b0, inj_rdv = 1'b0, pend = 1'b0;
   logic [31:0] s_data = '0, inj_data = '0, pend_data = '0;
   logic [31:0] cfg_id, cfg_ts;
   int          cfg_ws, cfg_lat;
   bit          cfg_mute_ts;

   assign bus_a.avm_waitrequest   = s_wait;
   assign bus_b.avm_waitrequest   = s_wait;
   assign bus_a.avm_readdatavalid = s_rdv | inj_rdv;
   assign bus_b.avm_readdatavalid = s_rdv | inj_rdv;
   assign bus_a.avm_readdata      = inj_rdv ? inj_data : s_data;
   assign bus_b.avm_readdata      = inj_rdv ? inj_data : s_data;

   always @(negedge clock) begin
      s_rdv  = 1'b0;
      s_wait = 1'b0;
      if (pend) begin
         s_rdv  = 1'b1;
         s_data = pend_data;
         pend   = 1'b0;
      end
      if (m_read) begin
         if (cfg_ws > 0) begin
            s_wait = 1'b1;
            cfg_ws = cfg_ws - 1;
         end else if (!(m_addr && cfg_mute_ts)) begin
            if (cfg_lat == 0) begin
               s_rdv  = 1'b1;
               s_data = m_addr ? cfg_ts : cfg_id;
            end else begin
               pend      = 1'b1;
               pend_data = m_addr ? cfg_ts : cfg_id;
            end
         end
      end
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Runs one check from a falling edge until done or max cycles; cycle 1 is the first
   // cycle after the start (or reset release) is sampled.
   task automatic run(input bit go, input int restart_at, input int max, output int cyc,
                      output int rd_id, output int rd_ts, output logic first_addr,
                      output logic last_addr, output logic [1:0] k1_flags);
      bit seen = 1'b0;
      cyc = 0; rd_id = 0; rd_ts = 0;
      first_addr = 1'b1; last_addr = 1'b0; k1_flags = 2'b11;
      start_cmd = go;
      do begin
         @(negedge clock);
         cyc++;
         start_cmd = (cyc == restart_at);
         if (cyc == 1) k1_flags = {m_done, m_timeout};
         if (m_read) begin
            if (!seen) first_addr = m_addr;
            seen      = 1'b1;
            last_addr = m_addr;
            if (m_addr) rd_ts++;
            else rd_id++;
         end
      end while (!m_done && cyc < max);
      start_cmd = 1'b0;
      if (!m_done) check_eq("done_within_budget", 32'(m_done), 32'd1);
   endtask

   int          cyc, rd_id, rd_ts;
   logic        fa, la;
   logic [1:0]  k1;

   initial begin
      rst_a_n = 1'b0; rst_b_n = 1'b0; start_cmd = 1'b0; sel = 1'b0;
      cfg_id = 32'd0; cfg_ts = EXP_TS; cfg_ws = 0; cfg_lat = 1; cfg_mute_ts = 1'b0;
      idle(3);
      check_eq("rst_busy", 32'(busy_a), 32'd0);
      check_eq("rst_done", 32'(done_a), 32'd0);
      check_eq("rst_read", 32'(bus_a.avm_read), 32'd0);
      check_eq("rst_idval", id_value_a, 32'd0);
      rst_b_n = 1'b1;

      // Auto-start after reset release
      rst_a_n = 1'b1;
      run(1'b0, 0, 40, cyc, rd_id, rd_ts, fa, la, k1);
      check_eq("auto_latency", 32'(cyc), 32'd5);
      check_eq("auto_pass", 32'(pass_a), 32'd1);
      check_eq("auto_flags", {30'd0, id_ok_a, ts_ok_a}, 32'd3);
      check_eq("auto_addr_first", 32'(fa), 32'd0);
      check_eq("auto_addr_last", 32'(la), 32'd1);
      check_eq("auto_busy", 32'(busy_a), 32'd0);
      check_eq("auto_tsval", ts_value_a, EXP_TS);

      // Wrong timestamp
      idle(2);
      cfg_ts = 32'h1234_5678;
      run(1'b1, 0, 40, cyc, rd_id, rd_ts, fa, la, k1);
      check_eq("badts_latency", 32'(cyc), 32'd5);
      check_eq("badts_flags", {28'd0, pass_a, id_ok_a, ts_ok_a, timeout_a}, 32'b0100);
      check_eq("badts_tsval", ts_value_a, 32'h1234_5678);

      // Wait states on the ID read
      idle(2);
      cfg_ts = EXP_TS; cfg_ws = 3;
      run(1'b1, 0, 40, cyc, rd_id, rd_ts, fa, la, k1);
      check_eq("ws_id_held", 32'(rd_id), 32'd4);
      check_eq("ws_ts_cycles", 32'(rd_ts), 32'd1);
      check_eq("ws_latency", 32'(cyc), 32'd8);
      check_eq("ws_pass", 32'(pass_a), 32'd1);

      // Timestamp read never answered
      idle(2);
      cfg_mute_ts = 1'b1;
      run(1'b1, 0, 60, cyc, rd_id, rd_ts, fa, la, k1);
      check_eq("to_latency", 32'(cyc), 32'd19);
      check_eq("to_flags", {28'd0, pass_a, id_ok_a, ts_ok_a, timeout_a}, 32'b0101);
      check_eq("to_read_low", 32'(bus_a.avm_read), 32'd0);
      cfg_mute_ts = 1'b0;

      // Stray readdatavalid in idle
      idle(2);
      inj_data = 32'hDEAD_BEEF; inj_rdv = 1'b1;
      idle(1);
      inj_rdv = 1'b0;
      idle(1);
      check_eq("stray_idval", id_value_a, 32'd0);
      check_eq("stray_tsval", ts_value_a, EXP_TS);
      check_eq("stray_state", {30'd0, busy_a, done_a}, 32'b01);

      // Restart clears flags; start while busy is ignored
      run(1'b1, 2, 40, cyc, rd_id, rd_ts, fa, la, k1);
      check_eq("restart_clear", 32'(k1), 32'd0);
      check_eq("restart_latency", 32'(cyc), 32'd5);
      check_eq("restart_pass", {30'd0, pass_a, timeout_a}, 32'b10);
      idle(4);
      check_eq("no_rerun", {30'd0, busy_a, done_a}, 32'b01);

      // Manual-start instance: reset during WAIT_ID then a stale readdatavalid
      sel = 1'b1;
      idle(2);
      check_eq("b_no_autostart", {30'd0, busy_b, done_b}, 32'd0);
      start_cmd = 1'b1;
      idle(1);
      start_cmd = 1'b0;
      idle(1);
      rst_b_n = 1'b0;
      idle(1);
      rst_b_n = 1'b1; inj_data = 32'hA5A5_A5A5; inj_rdv = 1'b1;
      idle(1);
      inj_rdv = 1'b0;
      check_eq("midrst_outs", {24'd0, bus_b.avm_read, busy_b, done_b, pass_b, id_ok_b,
                               ts_ok_b, timeout_b, 1'b0}, 32'd0);
      check_eq("midrst_idval", id_value_b, 32'd0);
      idle(2);
      check_eq("midrst_stay_idle", 32'(busy_b), 32'd0);
      run(1'b1, 0, 40, cyc, rd_id, rd_ts, fa, la, k1);
      check_eq("b_latency", 32'(cyc), 32'd5);
      check_eq("b_pass", 32'(pass_b), 32'd1);

      // Zero-latency slave skips the wait states
      idle(2);
      cfg_lat = 0;
      run(1'b1, 0, 40, cyc, rd_id, rd_ts, fa, la, k1);
      check_eq("zl_latency", 32'(cyc), 32'd3);
      check_eq("zl_pass", {29'd0, pass_b, id_ok_b, ts_ok_b}, 32'b111);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sysid_checker.md
Name: sysid_checker

Overview:
Avalon-MM read master that sits directly downstream of the system ID slave in the DE4 Qsys system. After reset or on request, it reads word 0 (system ID) and word 1 (build timestamp). It compares both against build-time expected values and reports pass/fail/timeout status. Boot logic and the LED status use this status to refuse mismatched FPGA images before the host driver proceeds.

Parameters:
EXPECTED_ID, 32'd0, expected value at slave word address 0
EXPECTED_TIMESTAMP, 32'd1434373291, expected value at slave word address 1
TIMEOUT_CYCLES, 1024, max cycles per read (issue to readdatavalid) before abort; legal range 2..65535
AUTO_START, 1, 1 = start a check automatically on the first cycle after reset release

Ports:
clock  in  1  system clock; sole clock domain
reset_n  in  1  synchronous, active-low reset
start  in  1  single-cycle pulse; begins a check when not busy
avm_address  out  1  word address to sysid slave (0 = ID, 1 = timestamp)
avm_read  out  1  Avalon read request
avm_waitrequest  in  1  fabric stall; read held while high
avm_readdata  in  32  read data
avm_readdatavalid  in  1  read data qualifier
busy  out  1  check in progress
done  out  1  check finished; held until next start
pass  out  1  id_ok & ts_ok & !timeout; valid when done
id_ok  out  1  captured ID == EXPECTED_ID
ts_ok  out  1  captured timestamp == EXPECTED_TIMESTAMP
timeout  out  1  a read exceeded TIMEOUT_CYCLES
id_value  out  32  captured ID word
ts_value  out  32  captured timestamp word

Behaviour:
- Reset: all sampled on the clock edge with reset_n low. All outputs go to 0, state goes to IDLE, and the timeout counter clears.
- Reset mid-operation: the read is abandoned immediately. A readdatavalid arriving later is ignored.
- FSM states: IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, DONE.
- IDLE:
  - Enter REQ_ID on start=1, or on the first post-reset cycle if AUTO_START=1.
  - On entry to REQ_ID, clear done, pass, id_ok, ts_ok and timeout, and set busy=1.
- REQ_x:
  - Drive avm_read=1 and avm_address=0 (ID) or 1 (TS).
  - Hold avm_read and avm_address stable while avm_waitrequest=1.
  - The command is accepted on a cycle with avm_read & !avm_waitrequest. avm_read drops on the following cycle, and the state moves to WAIT_x.
- Zero-latency case: if avm_readdatavalid=1 in the acceptance cycle, capture the data that cycle and skip WAIT_x. REQ_ID then goes to REQ_TS, and REQ_TS goes to DONE.
- WAIT_x: on avm_readdatavalid=1, capture avm_readdata into id_value or ts_value. Go to REQ_TS (from WAIT_ID) or DONE (from WAIT_TS).
- Compare flags: id_ok and ts_ok are registered on the capture cycle.
- Timeout counter:
  - Clears on entry to each REQ_x and increments every cycle in REQ_x or WAIT_x.
  - If it reaches TIMEOUT_CYCLES-1 with no capture, go to DONE with timeout=1 and avm_read=0.
  - Flags of the unread word stay 0.
  - Capture and timeout in the same cycle: capture wins, no timeout.
- DONE (one cycle):
  - Set done=1 and busy=0, and pass = id_ok & ts_ok & !timeout.
  - Return to IDLE; done and the flags hold.
- start while busy=1 is ignored. start in IDLE while done=1 restarts the check.
- avm_readdatavalid outside WAIT_x or the acceptance cycle is ignored, with no state or data change.
- Latency, zero-wait fabric with 1-cycle readdatavalid: start at cycle 0 → done=1 at cycle 5.
- Only one read is outstanding at a time.
- Counter width: $clog2(TIMEOUT_CYCLES+1).

Decomposition:
- Package sysid_check_pkg holds:
  - state enum sysid_state_t (the 6 states above)
  - localparams SYSID_ADDR_ID=1'b0, SYSID_ADDR_TS=1'b1
  - localparam SYSID_DATA_W=32
- No sub-module. The FSM, timeout counter and comparators stay in one file.

Test Plan:
- Reset release, AUTO_START=1, zero-wait slave returning ID=0 and TS=1434373291 with 1-cycle readdatavalid → avm_address sequence 0 then 1, done=1 at cycle 5, pass=1, id_ok=ts_ok=1.
- Slave returns TS=0x12345678 → done=1, pass=0, id_ok=1, ts_ok=0, ts_value=0x12345678, timeout=0.
- avm_waitrequest high 3 cycles on the ID read → avm_read and avm_address=0 held stable for 4 cycles, then normal completion with pass=1.
- TIMEOUT_CYCLES=16, slave never asserts readdatavalid for the TS read → done=1 exactly 16 cycles after TS request entry, timeout=1, pass=0, avm_read=0.
- reset_n low for 1 cycle during WAIT_ID, stale readdatavalid the cycle after release, AUTO_START=0 → all outputs 0, state IDLE, id_value stays 0. A subsequent start completes with pass=1.
- start pulsed while busy, and readdatavalid pulsed in IDLE → no restart, no data change. start after done → flags clear, a second check completes.
